// File: rtl/mem_access_unit.sv
// MEMPREP-stage load/store unit: drives a req/ack data-memory port, stalls the front of the
// pipeline while an access is outstanding, and registers the writeback bundle for WB.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              invalid_MEMPREP,
  input  logic [3:0]        rd_MEMPREP,
  input  logic [31:0]       alu_result_MEMPREP,
  input  logic [31:0]       store_data_MEMPREP,
  input  logic [2:0]        funct3_MEMPREP,
  input  logic              mem_read_MEMPREP,
  input  logic              mem_write_MEMPREP,
  input  logic              regfile_we_MEMPREP,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_MEMPREP,
  output logic              misaligned,
  output logic [3:0]        rd_WB,
  output logic [31:0]       result_WB,
  output logic              regfile_we_WB
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [3:0]  rd_q;
  logic        we_q;

  logic        memop;
  logic        store;
  logic        legal;
  logic        aligned;
  logic        go;
  logic [1:0]  lane;
  logic [31:0] wdata_next;
  logic [3:0]  be_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        load_signed;
  logic [31:0] load_data;

  assign lane  = alu_result_MEMPREP[1:0];
  assign memop = !invalid_MEMPREP && (mem_read_MEMPREP || mem_write_MEMPREP);
  // A slot that asserts both read and write is treated as a store.
  assign store = mem_write_MEMPREP;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    if (store) begin
      legal = (funct3_MEMPREP == 3'd0) || (funct3_MEMPREP == 3'd1) || (funct3_MEMPREP == 3'd2);
    end else begin
      legal = (funct3_MEMPREP == 3'd0) || (funct3_MEMPREP == 3'd1) || (funct3_MEMPREP == 3'd2) ||
              (funct3_MEMPREP == 3'd4) || (funct3_MEMPREP == 3'd5);
    end
    case (funct3_MEMPREP[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !lane[0];
      default: aligned = (lane == 2'd0);
    endcase
  end

  assign go = memop && legal && aligned;

  always_comb begin
    wdata_next = 32'h0;
    be_next    = 4'hF;
    if (store) begin
      case (funct3_MEMPREP[1:0])
        2'd0: begin
          wdata_next = {4{store_data_MEMPREP[7:0]}};
          be_next    = 4'b0001 << lane;
        end
        2'd1: begin
          wdata_next = {2{store_data_MEMPREP[15:0]}};
          be_next    = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_next = store_data_MEMPREP;
          be_next    = 4'hF;
        end
      endcase
    end
  end

  // Load extraction works on the lane and size latched when the request was issued.
  always_comb begin
    byte_sel    = 8'h0;
    half_sel    = 16'h0;
    load_signed = !funct3_q[2];
    load_data   = dmem_rdata;
    case (lane_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q[1:0])
      2'd0:    load_data = {{24{load_signed & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{load_signed & half_sel[15]}}, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  assign stall_MEMPREP = (state == IDLE) ? go : !dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      misaligned    <= 1'b0;
      rd_WB         <= 4'h0;
      result_WB     <= 32'h0;
      regfile_we_WB <= 1'b0;
      lane_q        <= 2'd0;
      funct3_q      <= 3'd0;
      rd_q          <= 4'h0;
      we_q          <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state         <= BUSY;
            dmem_req      <= 1'b1;
            dmem_we       <= store;
            dmem_addr     <= {alu_result_MEMPREP[ADDR_W-1:2], 2'b00};
            dmem_wdata    <= wdata_next;
            dmem_be       <= be_next;
            lane_q        <= lane;
            funct3_q      <= funct3_MEMPREP;
            rd_q          <= rd_MEMPREP;
            we_q          <= regfile_we_MEMPREP;
            regfile_we_WB <= 1'b0;
          end else begin
            // Bubbles and faulting memops still move rd/result but never write the regfile.
            rd_WB         <= rd_MEMPREP;
            result_WB     <= alu_result_MEMPREP;
            regfile_we_WB <= regfile_we_MEMPREP && !invalid_MEMPREP && !memop;
            misaligned    <= memop;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            rd_WB    <= rd_q;
            if (dmem_we) begin
              regfile_we_WB <= 1'b0;
            end else begin
              result_WB     <= load_data;
              regfile_we_WB <= we_q;
            end
          end else begin
            regfile_we_WB <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed table, multi-cycle corner sequences and randomized
// loads/stores checked against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        invalid_MEMPREP;
  logic [3:0]  rd_MEMPREP;
  logic [31:0] alu_result_MEMPREP;
  logic [31:0] store_data_MEMPREP;
  logic [2:0]  funct3_MEMPREP;
  logic        mem_read_MEMPREP;
  logic        mem_write_MEMPREP;
  logic        regfile_we_MEMPREP;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_MEMPREP;
  logic        misaligned;
  logic [3:0]  rd_WB;
  logic [31:0] result_WB;
  logic        regfile_we_WB;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .invalid_MEMPREP(invalid_MEMPREP), .rd_MEMPREP(rd_MEMPREP),
    .alu_result_MEMPREP(alu_result_MEMPREP), .store_data_MEMPREP(store_data_MEMPREP),
    .funct3_MEMPREP(funct3_MEMPREP), .mem_read_MEMPREP(mem_read_MEMPREP),
    .mem_write_MEMPREP(mem_write_MEMPREP), .regfile_we_MEMPREP(regfile_we_MEMPREP),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_MEMPREP(stall_MEMPREP), .misaligned(misaligned),
    .rd_WB(rd_WB), .result_WB(result_WB), .regfile_we_WB(regfile_we_WB)
  );

  typedef struct {
    logic        inv;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        rdm;
    logic        wrm;
    logic        we;
  } ins_t;

  typedef struct {
    logic        go;
    logic        store;
    logic [3:0]  rd;
    logic [31:0] res;
    logic        we;
    logic        mis;
    logic        chk_rd;
    logic        chk_res;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] sd;
    int          lane;
  } exp_t;

  typedef struct {
    string name;
    ins_t  ins;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] bus_mem [64];
  int          latency = 0;
  int          inject_req = 0;
  int          inject_done = 0;

  int          stall_cnt;
  int          req_cnt;
  logic        cap_seen;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  // Memory slave: acks each request after 'latency' wait cycles; can also emit a stray ack.
  initial begin : responder
    int  wait_cnt;
    bit  in_req;
    wait_cnt   = 0;
    in_req     = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      if (inject_req != inject_done) begin
        inject_done = inject_req;
        dmem_ack    = 1'b1;
        dmem_rdata  = $urandom;
      end else if (dmem_req && !rst) begin
        if (!in_req) begin
          in_req   = 1;
          wait_cnt = latency;
        end
        if (wait_cnt == 0) begin
          dmem_ack = 1'b1;
          in_req   = 0;
          if (dmem_we) begin
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) bus_mem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = bus_mem[dmem_addr[7:2]];
          end
        end else begin
          wait_cnt--;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input ins_t i);
    invalid_MEMPREP    = i.inv;
    rd_MEMPREP         = i.rd;
    alu_result_MEMPREP = i.alu;
    store_data_MEMPREP = i.sd;
    funct3_MEMPREP     = i.f3;
    mem_read_MEMPREP   = i.rdm;
    mem_write_MEMPREP  = i.wrm;
    regfile_we_MEMPREP = i.we;
  endtask

  // Called just after a rising edge; returns just after the edge that consumes the instruction.
  task automatic applyStimulus(input ins_t i);
    bit done;
    drive(i);
    stall_cnt = 0;
    req_cnt   = 0;
    cap_seen  = 0;
    done      = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (dmem_req) begin
        req_cnt++;
        if (!cap_seen) begin
          cap_seen  = 1;
          cap_addr  = dmem_addr;
          cap_wdata = dmem_wdata;
          cap_be    = dmem_be;
          cap_we    = dmem_we;
        end
      end
      if (!stall_MEMPREP) done = 1;
      else stall_cnt++;
    end
    if (!done) checkOutput("stall_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic inv, input logic [3:0] rd, input logic [31:0] alu,
                              input logic [31:0] sd, input logic [2:0] f3, input logic rdm,
                              input logic wrm, input logic we);
    ins_t i;
    i.inv = inv; i.rd = rd; i.alu = alu; i.sd = sd;
    i.f3 = f3; i.rdm = rdm; i.wrm = wrm; i.we = we;
    return i;
  endfunction

  function automatic exp_t mkExp(input logic [3:0] rd, input logic [31:0] res, input logic we,
                                 input logic mis, input logic chk);
    exp_t e;
    e = '{default: '0};
    e.rd = rd; e.res = res; e.we = we; e.mis = mis;
    e.chk_rd = chk; e.chk_res = chk;
    return e;
  endfunction

  // Reference: byte-addressed little-endian memory, updated as stores are issued.
  task automatic refModel(input ins_t i, output exp_t e);
    bit     memop, store, legal, aligned;
    int     size, a;
    longint v;
    memop = !i.inv && (i.rdm || i.wrm);
    store = i.wrm;
    case (i.f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    legal   = store ? (i.f3 <= 3'd2) : (i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a       = int'(i.alu[7:0]);
    aligned = (a % size) == 0;
    e = '{default: '0};
    e.rd = i.rd; e.res = i.alu; e.chk_rd = 1; e.chk_res = 1;
    e.go = memop && legal && aligned;
    e.store = store;
    e.addr = {i.alu[31:2], 2'b00};
    e.lane = a % 4;
    e.sd = i.sd;
    if (!memop) begin
      e.we = i.we && !i.inv;
    end else if (!e.go) begin
      e.mis = 1; e.chk_rd = 0; e.chk_res = 0;
    end else if (store) begin
      e.chk_res = 0;
      e.be = 4'h0;
      for (int k = 0; k < size; k++) begin
        ref_mem[a + k] = i.sd[8*k +: 8];
        e.be[(a % 4) + k] = 1'b1;
      end
    end else begin
      e.be = 4'hF;
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(ref_mem[a + k]) << (8 * k));
      if (!i.f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      e.res = v[31:0];
      e.we  = i.we;
    end
  endtask

  task automatic runAndCheck(input string tag, input ins_t i, input exp_t e);
    int exp_busy;
    applyStimulus(i);
    exp_busy = e.go ? latency + 1 : 0;
    checkOutput({tag, " stall_cycles"}, stall_cnt, exp_busy);
    checkOutput({tag, " req_cycles"}, req_cnt, exp_busy);
    checkOutput({tag, " regfile_we_WB"}, {31'h0, regfile_we_WB}, {31'h0, e.we});
    checkOutput({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, e.mis});
    if (e.chk_rd)  checkOutput({tag, " rd_WB"}, {28'h0, rd_WB}, {28'h0, e.rd});
    if (e.chk_res) checkOutput({tag, " result_WB"}, result_WB, e.res);
    if (e.go) begin
      checkOutput({tag, " dmem_addr"}, cap_addr, e.addr);
      checkOutput({tag, " dmem_we"}, {31'h0, cap_we}, {31'h0, e.store});
      checkOutput({tag, " dmem_be"}, {28'h0, cap_be}, {28'h0, e.be});
      if (e.store)
        for (int k = 0; k < 4; k++)
          if (e.be[k])
            checkOutput({tag, " dmem_wdata_lane"}, {24'h0, cap_wdata[8*k +: 8]},
                        {24'h0, e.sd[8*(k - e.lane) +: 8]});
    end
  endtask

  initial begin : main
    vec_t vecs[$];
    ins_t i;
    exp_t e;
    int   sz_mask, a;

    for (int w = 0; w < 64; w++) begin
      bus_mem[w] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*w + k] = bus_mem[w][8*k +: 8];
    end

    rst = 1'b1;
    drive(mk(1'b1, 4'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset dmem_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("reset regfile_we_WB", {31'h0, regfile_we_WB}, 32'h0);
    checkOutput("reset result_WB", result_WB, 32'h0);
    checkOutput("reset stall", {31'h0, stall_MEMPREP}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-cycle cases with hand-computed expectations.
    vecs.push_back('{"pass_through", mk(0, 4'd5, 32'h1234, 32'h0, 3'd0, 0, 0, 1), mkExp(4'd5, 32'h1234, 1, 0, 1)});
    vecs.push_back('{"no_write", mk(0, 4'd9, 32'hCAFEF00D, 32'h0, 3'd2, 0, 0, 0), mkExp(4'd9, 32'hCAFEF00D, 0, 0, 1)});
    vecs.push_back('{"invalid_alu", mk(1, 4'd3, 32'h55, 32'h0, 3'd0, 0, 0, 1), mkExp(4'd3, 32'h55, 0, 0, 1)});
    vecs.push_back('{"invalid_store", mk(1, 4'd7, 32'h40, 32'h99, 3'd2, 0, 1, 1), mkExp(4'd7, 32'h40, 0, 0, 1)});
    vecs.push_back('{"misaligned_lw", mk(0, 4'd2, 32'h102, 32'h0, 3'd2, 1, 0, 1), mkExp(4'd2, 32'h0, 0, 1, 0)});
    vecs.push_back('{"misaligned_lh", mk(0, 4'd2, 32'h11, 32'h0, 3'd1, 1, 0, 1), mkExp(4'd2, 32'h0, 0, 1, 0)});
    vecs.push_back('{"illegal_load_f3", mk(0, 4'd8, 32'h20, 32'h0, 3'd3, 1, 0, 1), mkExp(4'd8, 32'h0, 0, 1, 0)});
    vecs.push_back('{"illegal_store_f3", mk(0, 4'd8, 32'h20, 32'h0, 3'd4, 0, 1, 0), mkExp(4'd8, 32'h0, 0, 1, 0)});
    vecs.push_back('{"rw_store_misaligned", mk(0, 4'd1, 32'h21, 32'h0, 3'd2, 1, 1, 1), mkExp(4'd1, 32'h0, 0, 1, 0)});
    vecs.push_back('{"rw_store_wins_f3", mk(0, 4'd1, 32'h20, 32'h0, 3'd5, 1, 1, 1), mkExp(4'd1, 32'h0, 0, 1, 0)});
    vecs.push_back('{"after_fault", mk(0, 4'd15, 32'hA5A5A5A5, 32'h0, 3'd0, 0, 0, 1), mkExp(4'd15, 32'hA5A5A5A5, 1, 0, 1)});
    latency = 0;
    foreach (vecs[n]) runAndCheck(vecs[n].name, vecs[n].ins, vecs[n].e);

    // LB with sign bit set in the top byte, one wait cycle.
    bus_mem[0] = 32'h80FF_FFFF;
    ref_mem[0] = 8'hFF; ref_mem[1] = 8'hFF; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
    latency = 1;
    applyStimulus(mk(0, 4'd6, 32'h103, 32'h0, 3'd0, 1, 0, 1));
    checkOutput("lb dmem_addr", cap_addr, 32'h100);
    checkOutput("lb result_WB", result_WB, 32'hFFFF_FF80);
    checkOutput("lb regfile_we_WB", {31'h0, regfile_we_WB}, 32'h1);
    checkOutput("lb rd_WB", {28'h0, rd_WB}, 32'h6);
    checkOutput("lb stall_cycles", stall_cnt, 32'd2);

    // SH to the upper half with three wait cycles.
    latency = 3;
    i = mk(0, 4'd1, 32'h22, 32'hDEAD_BEEF, 3'd1, 0, 1, 0);
    refModel(i, e);
    applyStimulus(i);
    checkOutput("sh dmem_we", {31'h0, cap_we}, 32'h1);
    checkOutput("sh dmem_be", {28'h0, cap_be}, 32'hC);
    checkOutput("sh dmem_wdata", cap_wdata, 32'hBEEF_BEEF);
    checkOutput("sh req_cycles", req_cnt, 32'd4);
    checkOutput("sh regfile_we_WB", {31'h0, regfile_we_WB}, 32'h0);
    latency = 0;
    i = mk(0, 4'd4, 32'h20, 32'h0, 3'd2, 1, 0, 1);
    refModel(i, e);
    runAndCheck("sh_readback", i, e);

    // Reset in the middle of an access, then a stray ack.
    latency = 10;
    drive(mk(0, 4'd4, 32'h80, 32'h1234_5678, 3'd2, 0, 1, 0));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_busy dmem_req", {31'h0, dmem_req}, 32'h1);
    drive(mk(1, 4'd0, 32'h0, 32'h0, 3'd0, 0, 0, 0));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy dmem_req_cleared", {31'h0, dmem_req}, 32'h0);
    checkOutput("rst_busy bus", {dmem_addr[27:0], dmem_be} | dmem_wdata | {31'h0, dmem_we}, 32'h0);
    checkOutput("rst_busy wb", {27'h0, misaligned, rd_WB} | result_WB | {31'h0, regfile_we_WB}, 32'h0);
    checkOutput("rst_busy stall", {31'h0, stall_MEMPREP}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    inject_req++;
    @(posedge clk);
    #1;
    checkOutput("late_ack seen", {31'h0, dmem_ack}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("late_ack dmem_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("late_ack regfile_we_WB", {31'h0, regfile_we_WB}, 32'h0);
    latency = 0;
    runAndCheck("after_reset", mk(0, 4'd11, 32'h7777, 32'h0, 3'd0, 0, 0, 1), mkExp(4'd11, 32'h7777, 1, 0, 1));

    // Randomized mix of ALU ops, bubbles and loads/stores.
    for (int n = 0; n < 200; n++) begin
      i.inv = ($urandom_range(0, 9) == 0);
      i.rd  = 4'($urandom);
      i.sd  = $urandom;
      i.we  = 1'($urandom);
      i.rdm = 0;
      i.wrm = 0;
      case ($urandom_range(0, 3))
        0:       ;
        1:       i.wrm = 1;
        default: begin i.rdm = 1; i.wrm = ($urandom_range(0, 7) == 0); end
      endcase
      if ($urandom_range(0, 9) == 0) i.f3 = 3'($urandom);
      else if (i.wrm)                i.f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: i.f3 = 3'd0;
          1: i.f3 = 3'd1;
          2: i.f3 = 3'd2;
          3: i.f3 = 3'd4;
          default: i.f3 = 3'd5;
        endcase
      end
      sz_mask = (i.f3[1:0] == 2'd0) ? 0 : (i.f3[1:0] == 2'd1) ? 1 : 3;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0) a = a & ~sz_mask;
      i.alu = {24'($urandom), 8'(a)};
      latency = $urandom_range(0, 3);
      refModel(i, e);
      runAndCheck($sformatf("rand%0d", n), i, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
